// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause 22 MDIO PHY responder.
// Frame opcodes, frame-walker states, field widths, register indices.
package mdio_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] REG_CTRL   = 5'd0;
  localparam logic [ADDR_W-1:0] REG_STATUS = 5'd1;
  localparam logic [ADDR_W-1:0] REG_ID1    = 5'd2;
  localparam logic [ADDR_W-1:0] REG_ID2    = 5'd3;

  typedef enum logic [1:0] {
    WRITE = 2'b01,
    READ  = 2'b10
  } mdio_op_e;

  typedef enum logic [2:0] {
    PRE,
    ST,
    OP,
    PHYAD,
    REGAD,
    TA,
    DATA
  } mdio_state_e;

  // Registers backed by parameters rather than storage.
  function automatic logic is_ro(input logic [ADDR_W-1:0] a);
    return (a == REG_STATUS) || (a == REG_ID1) || (a == REG_ID2);
  endfunction

endpackage

// File: rtl/mdio_sync_edge.sv
// Two-flop synchronizers for MDC/MDIO plus an MDC rising-edge pulse.
// Ports: clk, rst, mdc, mdio in; mdc_rise (1 clk pulse), mdio_s out.
module mdio_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic mdc,
  input  logic mdio,
  output logic mdc_rise,
  output logic mdio_s
);

  logic [2:0] mdc_q;
  logic [1:0] mdio_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mdc_q  <= '0;
      mdio_q <= '0;
    end else begin
      mdc_q  <= {mdc_q[1:0], mdc};
      mdio_q <= {mdio_q[0], mdio};
    end
  end

  // mdc_q[1] is the synchronized level, mdc_q[2] its previous value.
  assign mdc_rise = mdc_q[1] & ~mdc_q[2];
  assign mdio_s   = mdio_q[1];

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause 22 MDIO target: decodes MDC/MDIO frames, serves 32x16 regs.
// Ports: clk_i/rst_i, mdc_i/mdio_i pins, mdio_o/mdio_oe_o drive,
// ctrl_o (reg 0), wr_valid_o/wr_addr_o/wr_data_o commit strobe.
module mdio_phy_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PhyAddr     = 5'd1,
  parameter int          PreambleLen = 32,
  parameter logic [15:0] PhyId1      = 16'h0141,
  parameter logic [15:0] PhyId2      = 16'h0DD0,
  parameter logic [15:0] StatusVal   = 16'h796D
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mdc_i,
  input  logic              mdio_i,
  output logic              mdio_o,
  output logic              mdio_oe_o,
  output logic [DATA_W-1:0] ctrl_o,
  output logic              wr_valid_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o
);

  localparam logic [5:0] PRE_MAX = 6'(PreambleLen);

  logic rise;
  logic bit_s;

  mdio_sync_edge u_sync (
    .clk      (clk_i),
    .rst      (rst_i),
    .mdc      (mdc_i),
    .mdio     (mdio_i),
    .mdc_rise (rise),
    .mdio_s   (bit_s)
  );

  mdio_state_e       state;
  logic [5:0]        pre_cnt;
  logic [3:0]        bit_cnt;
  logic              op_hi;
  logic              is_read;
  logic [ADDR_W-1:0] phy_q;
  logic [ADDR_W-1:0] reg_q;
  logic [DATA_W-1:0] shreg;
  logic              rd_act;
  logic              wr_act;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] wdata;

  always_comb begin
    rd_val = regs[reg_q];
    unique case (reg_q)
      REG_STATUS: rd_val = StatusVal;
      REG_ID1:    rd_val = PhyId1;
      REG_ID2:    rd_val = PhyId2;
      default:    rd_val = regs[reg_q];
    endcase
  end

  assign wdata  = {shreg[DATA_W-2:0], bit_s};
  assign ctrl_o = regs[REG_CTRL];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= PRE;
      pre_cnt    <= '0;
      bit_cnt    <= '0;
      op_hi      <= 1'b0;
      is_read    <= 1'b0;
      phy_q      <= '0;
      reg_q      <= '0;
      shreg      <= '0;
      rd_act     <= 1'b0;
      wr_act     <= 1'b0;
      mdio_o     <= 1'b0;
      mdio_oe_o  <= 1'b0;
      wr_valid_o <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      wr_valid_o <= 1'b0;
      if (rise) begin
        unique case (state)
          PRE: begin
            if (bit_s) begin
              if (pre_cnt != PRE_MAX) begin
                pre_cnt <= pre_cnt + 6'd1;
              end
            end else if (pre_cnt == PRE_MAX) begin
              state <= ST;
            end else begin
              pre_cnt <= '0;
            end
          end
          ST: begin
            pre_cnt <= '0;
            bit_cnt <= '0;
            state   <= bit_s ? OP : PRE;
          end
          OP: begin
            if (bit_cnt == 4'd0) begin
              op_hi   <= bit_s;
              bit_cnt <= 4'd1;
            end else begin
              bit_cnt <= '0;
              unique case ({op_hi, bit_s})
                READ: begin
                  is_read <= 1'b1;
                  state   <= PHYAD;
                end
                WRITE: begin
                  is_read <= 1'b0;
                  state   <= PHYAD;
                end
                default: state <= PRE;
              endcase
            end
          end
          PHYAD: begin
            phy_q <= {phy_q[ADDR_W-2:0], bit_s};
            if (bit_cnt == 4'd4) begin
              bit_cnt <= '0;
              state   <= REGAD;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          REGAD: begin
            reg_q <= {reg_q[ADDR_W-2:0], bit_s};
            if (bit_cnt == 4'd4) begin
              bit_cnt <= '0;
              state   <= TA;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          TA: begin
            if (bit_cnt == 4'd0) begin
              bit_cnt <= 4'd1;
              rd_act  <= is_read && (phy_q == PhyAddr);
              wr_act  <= !is_read && (phy_q == PhyAddr);
              // Master has released the line; drive TA bit 2 low.
              if (is_read && (phy_q == PhyAddr)) begin
                mdio_oe_o <= 1'b1;
                mdio_o    <= 1'b0;
                shreg     <= rd_val;
              end
            end else begin
              bit_cnt <= '0;
              state   <= DATA;
              if (rd_act) begin
                mdio_o <= shreg[DATA_W-1];
                shreg  <= {shreg[DATA_W-2:0], 1'b0};
              end
            end
          end
          DATA: begin
            if (rd_act) begin
              mdio_o <= shreg[DATA_W-1];
              shreg  <= {shreg[DATA_W-2:0], 1'b0};
            end else begin
              shreg <= wdata;
            end
            if (bit_cnt == 4'd15) begin
              state     <= PRE;
              pre_cnt   <= '0;
              bit_cnt   <= '0;
              rd_act    <= 1'b0;
              wr_act    <= 1'b0;
              mdio_oe_o <= 1'b0;
              mdio_o    <= 1'b0;
              if (wr_act && !is_ro(reg_q)) begin
                // Bit 15 of CTRL is a self-clearing soft reset.
                if (reg_q == REG_CTRL) begin
                  regs[reg_q] <= {1'b0, wdata[DATA_W-2:0]};
                end else begin
                  regs[reg_q] <= wdata;
                end
                wr_valid_o <= 1'b1;
                wr_addr_o  <= reg_q;
                wr_data_o  <= wdata;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          default: begin
            state   <= PRE;
            pre_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Self-checking bench for mdio_phy_responder: MDIO master model,
// vector table of frames, commit scoreboard, reset-mid-read sequence.
module tb_mdio_phy_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mdc = 1'b0;
  logic        drv = 1'b1;
  logic        mdio_line;
  logic        mdio_o;
  logic        mdio_oe_o;
  logic [15:0] ctrl_o;
  logic        wr_valid_o;
  logic [4:0]  wr_addr_o;
  logic [15:0] wr_data_o;

  int checks = 0;
  int passed = 0;

  logic [20:0] exp_q[$];
  logic [20:0] last_commit = '0;

  always #5 clk = ~clk;

  // Open-drain style bus with pull-up when nobody drives.
  assign mdio_line = mdio_oe_o ? mdio_o : drv;

  mdio_phy_responder dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .mdc_i      (mdc),
    .mdio_i     (mdio_line),
    .mdio_o     (mdio_o),
    .mdio_oe_o  (mdio_oe_o),
    .ctrl_o     (ctrl_o),
    .wr_valid_o (wr_valid_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wr_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", {11'd0, wr_addr_o, wr_data_o}, 32'hFFFFFFFF);
      end else begin
        chk("wr_commit", {11'd0, wr_addr_o, wr_data_o},
            {11'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic bit_cycle(input logic b, output logic s, output logic o);
    mdc = 1'b0;
    drv = b;
    repeat (8) @(negedge clk);
    s   = mdio_line;
    o   = mdio_oe_o;
    mdc = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic header(input logic wr, input logic [4:0] phy,
                        input logic [4:0] ra, input int pre,
                        output int oe_n, output logic ta2);
    logic s, o;
    oe_n = 0;
    for (int i = 0; i < pre; i++) begin
      bit_cycle(1'b1, s, o);
      oe_n += int'(o);
    end
    bit_cycle(1'b0, s, o); oe_n += int'(o);
    bit_cycle(1'b1, s, o); oe_n += int'(o);
    bit_cycle(!wr, s, o);  oe_n += int'(o);
    bit_cycle(wr, s, o);   oe_n += int'(o);
    for (int i = 4; i >= 0; i--) begin
      bit_cycle(phy[i], s, o);
      oe_n += int'(o);
    end
    for (int i = 4; i >= 0; i--) begin
      bit_cycle(ra[i], s, o);
      oe_n += int'(o);
    end
    bit_cycle(1'b1, s, o); oe_n += int'(o);
    bit_cycle(wr ? 1'b0 : 1'b1, ta2, o); oe_n += int'(o);
  endtask

  task automatic frame(input logic wr, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [15:0] data,
                       input int pre, output logic [15:0] rd,
                       output int oe_n, output logic ta2);
    logic s, o;
    header(wr, phy, ra, pre, oe_n, ta2);
    rd = '0;
    for (int i = 15; i >= 0; i--) begin
      bit_cycle(wr ? data[i] : 1'b1, s, o);
      rd = {rd[14:0], s};
      oe_n += int'(o);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [4:0]  phy;
    logic [4:0]  ra;
    logic [15:0] data;
    int          pre;
    logic        commit;
    logic [15:0] exp_rd;
    int          exp_oe;
    logic [15:0] exp_ctrl;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [15:0] rd;
    int          oe_n;
    logic        ta2;
    logic        s, o;

    vecs[0]  = '{1'b1, 5'd1, 5'd4, 16'hA5A5, 32, 1'b1, 16'h0000, 0,  16'h0000};
    vecs[1]  = '{1'b0, 5'd1, 5'd4, 16'h0000, 32, 1'b0, 16'hA5A5, 17, 16'h0000};
    vecs[2]  = '{1'b0, 5'd1, 5'd2, 16'h0000, 32, 1'b0, 16'h0141, 17, 16'h0000};
    vecs[3]  = '{1'b0, 5'd1, 5'd3, 16'h0000, 32, 1'b0, 16'h0DD0, 17, 16'h0000};
    vecs[4]  = '{1'b1, 5'd1, 5'd2, 16'hFFFF, 32, 1'b0, 16'h0000, 0,  16'h0000};
    vecs[5]  = '{1'b0, 5'd1, 5'd2, 16'h0000, 32, 1'b0, 16'h0141, 17, 16'h0000};
    vecs[6]  = '{1'b0, 5'd1, 5'd1, 16'h0000, 32, 1'b0, 16'h796D, 17, 16'h0000};
    vecs[7]  = '{1'b1, 5'd1, 5'd0, 16'h9140, 32, 1'b1, 16'h0000, 0,  16'h1140};
    vecs[8]  = '{1'b1, 5'd2, 5'd4, 16'h1234, 32, 1'b0, 16'h0000, 0,  16'h1140};
    vecs[9]  = '{1'b0, 5'd2, 5'd4, 16'h0000, 32, 1'b0, 16'hFFFF, 0,  16'h1140};
    vecs[10] = '{1'b0, 5'd1, 5'd4, 16'h0000, 32, 1'b0, 16'hA5A5, 17, 16'h1140};
    vecs[11] = '{1'b1, 5'd1, 5'd5, 16'h1111, 31, 1'b0, 16'h0000, 0,  16'h1140};
    vecs[12] = '{1'b0, 5'd1, 5'd5, 16'h0000, 32, 1'b0, 16'h0000, 17, 16'h1140};
    vecs[13] = '{1'b1, 5'd1, 5'd5, 16'h2222, 32, 1'b1, 16'h0000, 0,  16'h1140};
    vecs[14] = '{1'b0, 5'd1, 5'd5, 16'h0000, 32, 1'b0, 16'h2222, 17, 16'h1140};

    repeat (4) @(negedge clk);
    chk("rst_oe", {31'd0, mdio_oe_o}, 32'd0);
    chk("rst_mdio", {31'd0, mdio_o}, 32'd0);
    chk("rst_ctrl", {16'd0, ctrl_o}, 32'd0);
    chk("rst_wr", {10'd0, wr_valid_o, wr_addr_o, wr_data_o}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 15; v++) begin
      if (vecs[v].commit) begin
        exp_q.push_back({vecs[v].ra, vecs[v].data});
        last_commit = {vecs[v].ra, vecs[v].data};
      end
      frame(vecs[v].wr, vecs[v].phy, vecs[v].ra, vecs[v].data,
            vecs[v].pre, rd, oe_n, ta2);
      chk($sformatf("v%0d_oe_bits", v), oe_n, vecs[v].exp_oe);
      chk($sformatf("v%0d_pending", v), exp_q.size(), 0);
      chk($sformatf("v%0d_ctrl", v), {16'd0, ctrl_o}, {16'd0, vecs[v].exp_ctrl});
      chk($sformatf("v%0d_wr_hold", v), {11'd0, wr_addr_o, wr_data_o},
          {11'd0, last_commit});
      if (!vecs[v].wr) begin
        chk($sformatf("v%0d_rdata", v), {16'd0, rd}, {16'd0, vecs[v].exp_rd});
        chk($sformatf("v%0d_ta2", v), {31'd0, ta2},
            (vecs[v].exp_oe > 0) ? 32'd0 : 32'd1);
      end
    end

    // Reset pulse while read data bit 8 is on the wire.
    header(1'b0, 5'd1, 5'd4, 32, oe_n, ta2);
    for (int i = 0; i < 8; i++) bit_cycle(1'b1, s, o);
    mdc = 1'b0;
    drv = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_oe", {31'd0, mdio_oe_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_oe", {31'd0, mdio_oe_o}, 32'd0);
    chk("mid_rst_ctrl", {16'd0, ctrl_o}, 32'd0);
    chk("mid_rst_wr", {11'd0, wr_addr_o, wr_data_o}, 32'd0);
    rst = 1'b0;
    last_commit = '0;
    repeat (4) @(negedge clk);
    mdc = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 9; i < 16; i++) bit_cycle(1'b1, s, o);

    frame(1'b0, 5'd1, 5'd4, 16'h0, 32, rd, oe_n, ta2);
    chk("post_rst_reg4", {16'd0, rd}, 32'h0000);
    chk("post_rst_oe_bits", oe_n, 17);
    exp_q.push_back({5'd6, 16'hBEEF});
    frame(1'b1, 5'd1, 5'd6, 16'hBEEF, 32, rd, oe_n, ta2);
    chk("post_rst_pending", exp_q.size(), 0);
    frame(1'b0, 5'd1, 5'd6, 16'h0, 32, rd, oe_n, ta2);
    chk("post_rst_reg6", {16'd0, rd}, 32'h0000BEEF);
    frame(1'b0, 5'd1, 5'd0, 16'h0, 32, rd, oe_n, ta2);
    chk("post_rst_reg0", {16'd0, rd}, 32'h0000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
